// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator pair PUF measurement core.
// PUF_MAJORITY_VOTE_EN: repeat the measurement three times per start and majority-vote the bit.
package puf_pkg;
   timeunit 1ps;
   timeprecision 1ps;

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StRun,
      StSettle,
      StCmp,
      StDone
   } meas_state_e;

   // Challenge field positions, in units of SEL_W bits.
   localparam int unsigned CHAL_A_FIELD = 0;
   localparam int unsigned CHAL_B_FIELD = 1;

`ifdef PUF_MAJORITY_VOTE_EN
   localparam int unsigned NUM_RUNS = 3;
`else
   localparam int unsigned NUM_RUNS = 1;
`endif

   // CLR and CMP wrap every measurement window plus its settle time.
   localparam int unsigned RUN_OVERHEAD_CYC = 2;
   localparam int unsigned ERR_LATENCY      = 1;

   function automatic int unsigned meas_latency(input int unsigned win_cyc,
                                                input int unsigned settle_cyc);
      return NUM_RUNS * (win_cyc + settle_cyc + RUN_OVERHEAD_CYC) + 1;
   endfunction

endpackage

// File: rtl/puf_not.sv
// Single inverting stage of a PUF ring; the delay only shapes simulation timing.
module puf_not #(
   parameter int unsigned SIM_STAGE_DLY_PS = 250
) (
   input  logic a,
   output logic y
);
   timeunit 1ps;
   timeprecision 1ps;

`ifdef SYNTHESIS
   assign y = ~a;
`else
   assign #(SIM_STAGE_DLY_PS) y = ~a;
`endif

endmodule

// File: rtl/puf_ro.sv
// One enable-gated ring oscillator: a NAND enable stage followed by NUM_STAGES-1 inverters.
// With en low the NAND output is forced high, so the whole ring sits static.
module puf_ro #(
   parameter int unsigned NUM_STAGES       = 5,
   parameter int unsigned SIM_STAGE_DLY_PS = 250
) (
   input  logic en,
   output logic ring_out
);
   timeunit 1ps;
   timeprecision 1ps;

   logic [NUM_STAGES-1:0] node;

`ifdef SYNTHESIS
   assign node[0] = ~(en & node[NUM_STAGES-1]);
`else
   assign #(SIM_STAGE_DLY_PS) node[0] = ~(en & node[NUM_STAGES-1]);
`endif

   for (genvar i = 1; i < NUM_STAGES; i++) begin : g_stage
      puf_not #(
         .SIM_STAGE_DLY_PS(SIM_STAGE_DLY_PS)
      ) u_inv (
         .a(node[i-1]),
         .y(node[i])
      );
   end

   assign ring_out = node[0];

endmodule

// File: rtl/puf_ro_pair_meas.sv
// RO-pair PUF core: a challenge selects two rings, each clocks a saturating edge counter over a
// fixed i_clk window, and the counts are compared. PUF_MAJORITY_VOTE_EN selects 3-run voting.
module puf_ro_pair_meas
   import puf_pkg::*;
#(
   parameter int unsigned NUM_RO     = 16,
   parameter int unsigned NUM_STAGES = 5,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned WIN_CYC    = 1024,
   parameter int unsigned SETTLE_CYC = 4,
   parameter logic [NUM_RO-1:0][15:0] SIM_DLY_PS = {NUM_RO{16'd250}},
   localparam int unsigned SEL_W     = $clog2(NUM_RO)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [2*SEL_W-1:0] i_challenge,
   output logic               o_busy,
   output logic               o_valid,
   output logic               o_resp,
   output logic               o_tie,
   output logic               o_err,
   output logic [CNT_W-1:0]   o_cnt_a,
   output logic [CNT_W-1:0]   o_cnt_b
);
   timeunit 1ps;
   timeprecision 1ps;

   localparam int unsigned CYC_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
   localparam int unsigned CYC_W   = $clog2(CYC_MAX);

   meas_state_e       state_q;
   logic [SEL_W-1:0]  sel_a_q, sel_b_q;
   logic [CYC_W-1:0]  cyc_q;
   logic [1:0]        run_q, vote_q, tie_q;
   logic [NUM_RO-1:0] ro_en_q, ro_out, ring_mask;
   logic              cnt_clr_q;

   logic [SEL_W-1:0]  chal_a, chal_b;
   logic              ring_clk_a, ring_clk_b, cnt_rst_n;
   logic [CNT_W-1:0]  cnt_a_q, cnt_b_q;
   logic              cnt_gt, cnt_eq;
   logic [1:0]        vote_nxt, tie_nxt;

   assign chal_a = i_challenge[CHAL_A_FIELD*SEL_W +: SEL_W];
   assign chal_b = i_challenge[CHAL_B_FIELD*SEL_W +: SEL_W];

   for (genvar i = 0; i < NUM_RO; i++) begin : g_ro
      puf_ro #(
         .NUM_STAGES      (NUM_STAGES),
         .SIM_STAGE_DLY_PS(32'(SIM_DLY_PS[i]))
      ) u_ro (
         .en      (ro_en_q[i]),
         .ring_out(ro_out[i])
      );
   end

   // Selects only change in IDLE, when every ring is parked high, so the muxed clocks cannot glitch.
   assign ring_clk_a = ro_out[sel_a_q];
   assign ring_clk_b = ro_out[sel_b_q];
   assign cnt_rst_n  = i_rst_n & ~cnt_clr_q;

   always_ff @(posedge ring_clk_a or negedge cnt_rst_n) begin
      if (!cnt_rst_n) begin
         cnt_a_q <= '0;
      end else if (cnt_a_q != '1) begin
         cnt_a_q <= cnt_a_q + CNT_W'(1);
      end
   end

   always_ff @(posedge ring_clk_b or negedge cnt_rst_n) begin
      if (!cnt_rst_n) begin
         cnt_b_q <= '0;
      end else if (cnt_b_q != '1) begin
         cnt_b_q <= cnt_b_q + CNT_W'(1);
      end
   end

   // Counts are static by CMP (rings stopped during SETTLE), so they are read without synchronisers.
   always_comb begin
      cnt_gt   = cnt_a_q > cnt_b_q;
      cnt_eq   = cnt_a_q == cnt_b_q;
      vote_nxt = vote_q + {1'b0, cnt_gt};
      tie_nxt  = tie_q + {1'b0, cnt_eq};
   end

   always_comb begin
      ring_mask          = '0;
      ring_mask[sel_a_q] = 1'b1;
      ring_mask[sel_b_q] = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= StIdle;
         sel_a_q   <= '0;
         sel_b_q   <= '0;
         cyc_q     <= '0;
         run_q     <= '0;
         vote_q    <= '0;
         tie_q     <= '0;
         ro_en_q   <= '0;
         cnt_clr_q <= 1'b0;
         o_busy    <= 1'b0;
         o_valid   <= 1'b0;
         o_resp    <= 1'b0;
         o_tie     <= 1'b0;
         o_err     <= 1'b0;
         o_cnt_a   <= '0;
         o_cnt_b   <= '0;
      end else begin
         o_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (i_start) begin
                  sel_a_q <= chal_a;
                  sel_b_q <= chal_b;
                  run_q   <= '0;
                  vote_q  <= '0;
                  tie_q   <= '0;
                  if (chal_a == chal_b) begin
                     o_err   <= 1'b1;
                     o_resp  <= 1'b0;
                     o_tie   <= 1'b0;
                     o_valid <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     o_err     <= 1'b0;
                     o_busy    <= 1'b1;
                     cnt_clr_q <= 1'b1;
                     state_q   <= StClr;
                  end
               end
            end
            StClr: begin
               cnt_clr_q <= 1'b0;
               ro_en_q   <= ring_mask;
               cyc_q     <= '0;
               state_q   <= StRun;
            end
            StRun: begin
               if (cyc_q == CYC_W'(WIN_CYC - 1)) begin
                  ro_en_q <= '0;
                  cyc_q   <= '0;
                  state_q <= StSettle;
               end else begin
                  cyc_q <= cyc_q + CYC_W'(1);
               end
            end
            StSettle: begin
               if (cyc_q == CYC_W'(SETTLE_CYC - 1)) begin
                  cyc_q   <= '0;
                  state_q <= StCmp;
               end else begin
                  cyc_q <= cyc_q + CYC_W'(1);
               end
            end
            StCmp: begin
               vote_q <= vote_nxt;
               tie_q  <= tie_nxt;
               if (run_q == 2'(NUM_RUNS - 1)) begin
                  o_cnt_a <= cnt_a_q;
                  o_cnt_b <= cnt_b_q;
                  // Majority: more than half of the runs had A strictly faster.
                  o_resp  <= {vote_nxt, 1'b0} > 3'(NUM_RUNS);
                  o_tie   <= tie_nxt == 2'(NUM_RUNS);
                  o_valid <= 1'b1;
                  o_busy  <= 1'b0;
                  state_q <= StDone;
               end else begin
                  run_q     <= run_q + 2'd1;
                  cnt_clr_q <= 1'b1;
                  state_q   <= StClr;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   int unsigned lat_cyc;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lat_cyc <= 0;
      end else if (state_q == StIdle) begin
         lat_cyc <= 1;
      end else begin
         lat_cyc <= lat_cyc + 1;
      end
   end

   a_latency: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (state_q == StDone) |-> (lat_cyc == ((sel_a_q == sel_b_q) ?
                                           ERR_LATENCY : meas_latency(WIN_CYC, SETTLE_CYC))));
`endif

endmodule
